// File: rtl/reg_access_ctrl_pkg.sv
// Shared types and constants for the register-bank access controller and the bank itself.
// Pure definitions: no latency, no flow control.
package reg_access_ctrl_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int SEL_W_DEF = 5;
    localparam int REG_ZERO  = 0;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD1  = 3'd2,
        RD2  = 3'd3,
        RESP = 3'd4
    } state_e;

endpackage

// File: rtl/reg_access_ctrl.sv
// Serializes operand reads and writebacks onto the single-port register bank; write 2 cycles/op, read rsp 2 cycles after accept.
// Backpressure: only IDLE accepts requests (writeback wins); RESP holds the response until rsp_ready.
module reg_access_ctrl
    import reg_access_ctrl_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rd_valid,
    output logic             rd_ready,
    input  logic [SEL_W-1:0] rd_rs1,
    input  logic [SEL_W-1:0] rd_rs2,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [XLEN-1:0]  rsp_rs1_data,
    output logic [XLEN-1:0]  rsp_rs2_data,
    input  logic             wb_valid,
    output logic             wb_ready,
    input  logic [SEL_W-1:0] wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    output logic [SEL_W-1:0] bank_select,
    output logic             bank_write,
    output logic [XLEN-1:0]  bank_dataIn,
    input  logic [XLEN-1:0]  bank_dataOut
);

    localparam logic [SEL_W-1:0] ZERO_IDX = SEL_W'(REG_ZERO);

    state_e           state_q;
    logic [SEL_W-1:0] rs2_q;
    logic             rsp_valid_q;
    logic [XLEN-1:0]  rs1_data_q;
    logic [XLEN-1:0]  rs2_data_q;
    logic [SEL_W-1:0] select_q;
    logic             write_q;
    logic [XLEN-1:0]  data_in_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rs2_q       <= '0;
            rsp_valid_q <= 1'b0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            select_q    <= '0;
            write_q     <= 1'b0;
            data_in_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (wb_valid) begin
                        select_q  <= wb_rd;
                        data_in_q <= wb_data;
                        write_q   <= (wb_rd != ZERO_IDX);
                        state_q   <= WR;
                    end else if (rd_valid) begin
                        select_q  <= rd_rs1;
                        rs2_q     <= rd_rs2;
                        state_q   <= RD1;
                    end
                end
                WR: begin
                    write_q <= 1'b0;
                    state_q <= IDLE;
                end
                RD1: begin
                    // select_q still holds rs1 here; bank_dataOut is its value
                    rs1_data_q <= (select_q == ZERO_IDX) ? '0 : bank_dataOut;
                    select_q   <= rs2_q;
                    state_q    <= RD2;
                end
                RD2: begin
                    rs2_data_q  <= (rs2_q == ZERO_IDX) ? '0 : bank_dataOut;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wb_ready     = (state_q == IDLE);
    assign rd_ready     = (state_q == IDLE) & ~wb_valid;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rs1_data = rs1_data_q;
    assign rsp_rs2_data = rs2_data_q;
    assign bank_select  = select_q;
    assign bank_dataIn  = data_in_q;
    // The bank commits on the same edge that clears write_q, so reset must mask it to abort a pending write.
    assign bank_write   = write_q & ~reset;

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Bench for reg_access_ctrl with a behavioural single-port bank; x0 of the bank model holds junk on purpose.
module tb_reg_access_ctrl;

    localparam int XLEN  = 32;
    localparam int SEL_W = 5;
    localparam logic [31:0] X0_JUNK = 32'hBAD0_BAD0;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             rd_valid = 1'b0;
    logic             rd_ready;
    logic [SEL_W-1:0] rd_rs1 = '0;
    logic [SEL_W-1:0] rd_rs2 = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [XLEN-1:0]  rsp_rs1_data;
    logic [XLEN-1:0]  rsp_rs2_data;
    logic             wb_valid = 1'b0;
    logic             wb_ready;
    logic [SEL_W-1:0] wb_rd = '0;
    logic [XLEN-1:0]  wb_data = '0;
    logic [SEL_W-1:0] bank_select;
    logic             bank_write;
    logic [XLEN-1:0]  bank_dataIn;
    logic [XLEN-1:0]  bank_dataOut;

    logic             bank_init = 1'b1;
    logic [XLEN-1:0]  bank_q [32];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bank_init) begin
            for (int i = 0; i < 32; i++) bank_q[i] <= (i == 0) ? X0_JUNK : 32'h0;
        end else if (bank_write) begin
            bank_q[bank_select] <= bank_dataIn;
        end
    end
    assign bank_dataOut = bank_q[bank_select];

    reg_access_ctrl #(.XLEN(XLEN), .SEL_W(SEL_W)) dut (
        .clk(clk), .reset(reset),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_rs1(rd_rs1), .rd_rs2(rd_rs2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rs1_data(rsp_rs1_data), .rsp_rs2_data(rsp_rs2_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .bank_select(bank_select), .bank_write(bank_write),
        .bank_dataIn(bank_dataIn), .bank_dataOut(bank_dataOut)
    );

    typedef struct {
        logic        is_wr;
        logic [4:0]  a;      // wb_rd or rs1
        logic [4:0]  b;      // rs2
        logic [31:0] wdata;
        logic [31:0] exp1;   // rs1 data, or bank content after write
        logic [31:0] exp2;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [4:0] rd, input logic [31:0] data, input logic [31:0] bank_exp);
        wb_valid = 1'b1; wb_rd = rd; wb_data = data;
        #1;
        check("wr_wb_ready_idle", {31'b0, wb_ready}, 32'd1);
        tick();
        wb_valid = 1'b0; wb_rd = ~rd; wb_data = ~data;
        check("wr_bank_write", {31'b0, bank_write}, {31'b0, rd != 5'd0});
        check("wr_bank_select", {27'b0, bank_select}, {27'b0, rd});
        check("wr_bank_dataIn", bank_dataIn, data);
        check("wr_wb_ready_busy", {31'b0, wb_ready}, 32'd0);
        tick();
        check("wr_write_drop", {31'b0, bank_write}, 32'd0);
        check("wr_wb_ready_back", {31'b0, wb_ready}, 32'd1);
        check("wr_bank_content", bank_q[rd], bank_exp);
    endtask

    task automatic do_read(input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] e1, input logic [31:0] e2);
        rd_valid = 1'b1; rd_rs1 = rs1; rd_rs2 = rs2;
        #1;
        check("rd_ready_idle", {31'b0, rd_ready}, 32'd1);
        tick();
        rd_valid = 1'b0; rd_rs1 = ~rs1; rd_rs2 = ~rs2;
        check("rd_rsp_valid_e0", {31'b0, rsp_valid}, 32'd0);
        check("rd_ready_busy", {31'b0, rd_ready}, 32'd0);
        tick();
        check("rd_rsp_valid_e1", {31'b0, rsp_valid}, 32'd0);
        tick();
        check("rd_rsp_valid_e2", {31'b0, rsp_valid}, 32'd1);
        check("rd_rs1_data", rsp_rs1_data, e1);
        check("rd_rs2_data", rsp_rs2_data, e2);
        tick();
        check("rd_rsp_done", {31'b0, rsp_valid}, 32'd0);
        check("rd_ready_back", {31'b0, rd_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 5'd1,  5'd2,  32'h0,         32'h0,         32'h0};
        vecs[1] = '{1'b1, 5'd5,  5'd0,  32'hDEADBEEF,  32'hDEADBEEF,  32'h0};
        vecs[2] = '{1'b0, 5'd5,  5'd0,  32'h0,         32'hDEADBEEF,  32'h0};
        vecs[3] = '{1'b1, 5'd0,  5'd0,  32'hFFFFFFFF,  X0_JUNK,       32'h0};
        vecs[4] = '{1'b0, 5'd0,  5'd0,  32'h0,         32'h0,         32'h0};
        vecs[5] = '{1'b1, 5'd31, 5'd0,  32'h0BADF00D,  32'h0BADF00D,  32'h0};
        vecs[6] = '{1'b0, 5'd31, 5'd5,  32'h0,         32'h0BADF00D,  32'hDEADBEEF};
        vecs[7] = '{1'b0, 5'd2,  5'd31, 32'h0,         32'h0,         32'h0BADF00D};

        repeat (2) tick();
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rs1_data", rsp_rs1_data, 32'd0);
        check("rst_rs2_data", rsp_rs2_data, 32'd0);
        check("rst_bank_select", {27'b0, bank_select}, 32'd0);
        check("rst_bank_write", {31'b0, bank_write}, 32'd0);
        check("rst_bank_dataIn", bank_dataIn, 32'd0);
        reset = 1'b0; bank_init = 1'b0;
        #1;
        check("idle_wb_ready", {31'b0, wb_ready}, 32'd1);
        check("idle_rd_ready", {31'b0, rd_ready}, 32'd1);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].is_wr) do_write(vecs[i].a, vecs[i].wdata, vecs[i].exp1);
            else               do_read(vecs[i].a, vecs[i].b, vecs[i].exp1, vecs[i].exp2);
        end

        // Simultaneous write and read: write must win and the read must see it.
        wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h12345678;
        rd_valid = 1'b1; rd_rs1 = 5'd7; rd_rs2 = 5'd7;
        #1;
        check("both_rd_ready", {31'b0, rd_ready}, 32'd0);
        check("both_wb_ready", {31'b0, wb_ready}, 32'd1);
        tick();
        wb_valid = 1'b0;
        check("both_wr_first", {31'b0, bank_write}, 32'd1);
        check("both_wr_select", {27'b0, bank_select}, 32'd7);
        tick();
        check("both_rd_ready_after", {31'b0, rd_ready}, 32'd1);
        tick();
        rd_valid = 1'b0;
        check("both_rd_select", {27'b0, bank_select}, 32'd7);
        tick(); tick();
        check("both_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        check("both_rs1", rsp_rs1_data, 32'h12345678);
        check("both_rs2", rsp_rs2_data, 32'h12345678);
        tick();
        check("both_done", {31'b0, rsp_valid}, 32'd0);

        // Response backpressure.
        rsp_ready = 1'b0;
        rd_valid = 1'b1; rd_rs1 = 5'd5; rd_rs2 = 5'd31;
        tick();
        rd_valid = 1'b0;
        begin
            int n = 0;
            while (!rsp_valid && n < 10) begin tick(); n++; end
            check("bp_rsp_arrives", {31'b0, rsp_valid}, 32'd1);
        end
        for (int c = 0; c < 5; c++) begin
            check("bp_hold_valid", {31'b0, rsp_valid}, 32'd1);
            check("bp_hold_rs1", rsp_rs1_data, 32'hDEADBEEF);
            check("bp_hold_rs2", rsp_rs2_data, 32'h0BADF00D);
            check("bp_rd_ready", {31'b0, rd_ready}, 32'd0);
            check("bp_wb_ready", {31'b0, wb_ready}, 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_valid", {31'b0, rsp_valid}, 32'd1);
        tick();
        check("bp_after_valid", {31'b0, rsp_valid}, 32'd0);
        check("bp_after_rd_ready", {31'b0, rd_ready}, 32'd1);

        // Reset in the cycle after a write is accepted: the write must not commit.
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'hA5A5A5A5;
        tick();
        wb_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstwr_bank_reg3", bank_q[3], 32'h0);
        check("rstwr_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rstwr_bank_write", {31'b0, bank_write}, 32'd0);
        check("rstwr_bank_select", {27'b0, bank_select}, 32'd0);
        check("rstwr_wb_ready", {31'b0, wb_ready}, 32'd1);

        // Reset while a response is pending discards it.
        do_read(5'd3, 5'd5, 32'h0, 32'hDEADBEEF);
        rsp_ready = 1'b0;
        rd_valid = 1'b1; rd_rs1 = 5'd31; rd_rs2 = 5'd31;
        tick();
        rd_valid = 1'b0;
        tick(); tick();
        check("rstrsp_pending", {31'b0, rsp_valid}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rsp_ready = 1'b1;
        check("rstrsp_discard", {31'b0, rsp_valid}, 32'd0);
        check("rstrsp_rs1_clear", rsp_rs1_data, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
